// File: rtl/ram_pkg.sv
// Shared response codes and FSM state types for the handshake-driven main memory.
package ram_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic       {W_IDLE, W_RESP}         wr_state_e;

endpackage

// File: rtl/ram_axi_slave_if.sv
// AXI-style read (AR/R) and write (AW/W/B) channel bundle between the core arbiter and memory.
interface ram_axi_slave_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  import ram_pkg::*;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  resp_t                 r_resp;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  b_valid;
  logic                  b_ready;
  resp_t                 b_resp;

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/ram_array.sv
// DEPTH x DATA_W storage: byte-strobed sync write, registered sync read, async 32-bit fetch.
module ram_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1048576,
  localparam int NB    = DATA_W / 8,
  localparam int OFF   = $clog2(NB),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_strb,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  fe_idx,
  input  logic [OFF-1:0]    fe_sel,
  output logic [31:0]       fe_inst
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] fe_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read register samples pre-write contents when a commit hits the same word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

  always_comb begin
    fe_word = mem[fe_idx];
    fe_inst = 32'(fe_word >> (32 * (fe_sel >> 2)));
  end

endmodule

// File: rtl/ram_axi_slave.sv
// Main memory slave: read FSM with latency countdown, write FSM collecting AW/W in any order.
// R_IDLE accept AR | R_WAIT latency countdown | R_RESP hold R ; W_IDLE collect AW+W | W_RESP hold B
module ram_axi_slave
  import ram_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 1048576,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_axi_slave_if.slave    bus,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst
);

  localparam int         NB    = DATA_W / 8;
  localparam int         OFF   = $clog2(NB);
  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'(NB);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] o;
    o = a - BASE;
    return (a >= BASE) && (64'(o) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> OFF);
  endfunction

  rd_state_e         r_state_q, r_state_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  resp_t             r_resp_q, r_resp_d;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  wr_state_e         w_state_q, w_state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [NB-1:0]     w_strb_q, w_strb_d;
  resp_t             b_resp_q, b_resp_d;
  logic              aw_hs, w_hs, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_strb;

  logic [31:0]       fe_inst;

  always_comb begin
    r_state_d    = r_state_q;
    lat_cnt_d    = lat_cnt_q;
    r_resp_d     = r_resp_q;
    rd_en        = 1'b0;
    rd_idx       = addr_idx(bus.ar_addr);
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        bus.ar_ready = 1'b1;
        if (bus.ar_valid) begin
          rd_en    = addr_ok(bus.ar_addr);
          r_resp_d = addr_ok(bus.ar_addr) ? RESP_OKAY : RESP_DECERR;
          if (RD_LAT > 1) begin
            r_state_d = R_WAIT;
            lat_cnt_d = 3'(RD_LAT - 2);
          end else begin
            r_state_d = R_RESP;
          end
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == 3'd0) r_state_d = R_RESP;
        else                   lat_cnt_d = lat_cnt_q - 3'd1;
      end
      R_RESP: begin
        bus.r_valid = 1'b1;
        if (bus.r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      lat_cnt_q <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      lat_cnt_q <= lat_cnt_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // The data register only loads on in-range reads, so decode errors are zeroed here.
  assign bus.r_data = (r_resp_q == RESP_OKAY) ? rd_word : '0;
  assign bus.r_resp = r_resp_q;

  always_comb begin
    w_state_d    = w_state_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    aw_addr_d    = aw_addr_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    b_resp_d     = b_resp_q;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = aw_got_q ? aw_addr_q : bus.aw_addr;
    wr_data      = w_got_q ? w_data_q : bus.w_data;
    wr_strb      = w_got_q ? w_strb_q : bus.w_strb;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        bus.aw_ready = !aw_got_q;
        bus.w_ready  = !w_got_q;
        aw_hs        = bus.aw_valid && !aw_got_q;
        w_hs         = bus.w_valid && !w_got_q;
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_en     = addr_ok(wr_addr);
          b_resp_d  = addr_ok(wr_addr) ? RESP_OKAY : RESP_DECERR;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_got_d  = 1'b1;
            aw_addr_d = bus.aw_addr;
          end
          if (w_hs) begin
            w_got_d  = 1'b1;
            w_data_d = bus.w_data;
            w_strb_d = bus.w_strb;
          end
        end
      end
      W_RESP: begin
        bus.b_valid = 1'b1;
        if (bus.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
    end
  end

  assign bus.b_resp = b_resp_q;

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (addr_idx(wr_addr)),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_word),
    .fe_idx  (addr_idx(if_addr)),
    .fe_sel  (if_addr[OFF-1:0]),
    .fe_inst (fe_inst)
  );

  assign if_inst = addr_ok(if_addr) ? fe_inst : 32'd0;

endmodule

// File: tb/tb_ram_axi_slave.sv
// Self-checking bench for ram_axi_slave: directed vector table, corner sequences, random ops vs. a word-array model.
module tb_ram_axi_slave;
  import ram_pkg::*;

  localparam int          DATA_W = 64;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam longint      SPAN   = longint'(DEPTH) * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_addr;
  logic [31:0] if_inst;

  ram_axi_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_axi_slave #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BASE   (BASE),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .if_addr (if_addr),
    .if_inst (if_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_mem [int];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within bound, expected one", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + SPAN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 8);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? RESP_OKAY : RESP_DECERR;
  endfunction

  function automatic logic [63:0] exp_read(input logic [31:0] a);
    if (!in_rng(a) || !ref_mem.exists(widx(a))) return 64'h0;
    return ref_mem[widx(a)];
  endfunction

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    logic [63:0] w;
    if (!in_rng(a)) return 32'h0;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 64'h0;
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    if (!in_rng(a)) return;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 64'h0;
    for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[widx(a)] = w;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    int n = 0;
    bus.aw_addr  = a;
    bus.w_data   = d;
    bus.w_strb   = s;
    bus.aw_valid = 1'b1;
    bus.w_valid  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      bit aw_acc;
      bit w_acc;
      aw_acc = bus.aw_valid && bus.aw_ready;
      w_acc  = bus.w_valid && bus.w_ready;
      step();
      n++;
      if (aw_acc) begin bus.aw_valid = 1'b0; aw_done = 1; end
      if (w_acc)  begin bus.w_valid  = 1'b0; w_done  = 1; end
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    if (!(aw_done && w_done)) timeout("write_accept");
    n = 0;
    while (!bus.b_valid && n < 20) begin step(); n++; end
    if (!bus.b_valid) timeout("write_b");
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                         output int lat);
    int n = 0;
    bus.ar_addr  = a;
    bus.ar_valid = 1'b1;
    while (!bus.ar_ready && n < 20) begin step(); n++; end
    if (!bus.ar_ready) timeout("read_ar");
    step();
    bus.ar_valid = 1'b0;
    lat = 1;
    while (!bus.r_valid && lat < 20) begin step(); lat++; end
    if (!bus.r_valid) timeout("read_r");
    d    = bus.r_data;
    resp = bus.r_resp;
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] rdat;
    logic [63:0] held;
    int          lat;
    int          n;

    vecs.push_back('{1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, RESP_OKAY,   64'h0,                 "wr_full"});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0,                8'h00, RESP_OKAY,   64'h1122334455667788, "rd_full"});
    vecs.push_back('{1'b1, 32'h8000_0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, RESP_OKAY,   64'h0,                 "wr_low_strb"});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0,                8'h00, RESP_OKAY,   64'h11223344BBBBBBBB, "rd_low_strb"});
    vecs.push_back('{1'b0, 32'h7FFF_FFF8, 64'h0,                8'h00, RESP_DECERR, 64'h0,                 "rd_below_base"});
    vecs.push_back('{1'b1, 32'h9000_0000, 64'hDEADBEEFDEADBEEF, 8'hFF, RESP_DECERR, 64'h0,                 "wr_far_decerr"});
    vecs.push_back('{1'b1, 32'h8000_2010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, RESP_DECERR, 64'h0,                 "wr_alias_decerr"});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0,                8'h00, RESP_OKAY,   64'h11223344BBBBBBBB, "rd_unchanged"});
    vecs.push_back('{1'b1, 32'h8000_0017, 64'hCC00000000000000, 8'h80, RESP_OKAY,   64'h0,                 "wr_top_byte"});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0,                8'h00, RESP_OKAY,   64'hCC223344BBBBBBBB, "rd_top_byte"});
    vecs.push_back('{1'b1, 32'h8000_1FF8, 64'h0123456789ABCDEF, 8'hFF, RESP_OKAY,   64'h0,                 "wr_last_word"});
    vecs.push_back('{1'b0, 32'h8000_1FFF, 64'h0,                8'h00, RESP_OKAY,   64'h0123456789ABCDEF, "rd_last_word"});
    vecs.push_back('{1'b1, 32'h8000_2000, 64'h5A5A5A5A5A5A5A5A, 8'hFF, RESP_DECERR, 64'h0,                 "wr_past_end"});
    vecs.push_back('{1'b0, 32'h8000_2000, 64'h0,                8'h00, RESP_DECERR, 64'h0,                 "rd_past_end"});

    rst          = 1'b1;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.r_ready = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.w_valid = 1'b0;
    bus.w_data   = '0;   bus.w_strb  = '0; bus.b_ready = 1'b0;
    if_addr      = BASE;
    #12;
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'h1);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'h1);
    chk("rst_w_ready",  64'(bus.w_ready),  64'h1);
    chk("rst_r_valid",  64'(bus.r_valid),  64'h0);
    chk("rst_b_valid",  64'(bus.b_valid),  64'h0);
    chk("rst_r_data",   bus.r_data,        64'h0);
    chk("rst_r_resp",   64'(bus.r_resp),   64'h0);
    chk("rst_b_resp",   64'(bus.b_resp),   64'h0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        chk({vecs[i].name, "_bresp"}, 64'(resp), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, rdat, resp, lat);
        chk({vecs[i].name, "_rresp"}, 64'(resp), 64'(vecs[i].exp_resp));
        chk({vecs[i].name, "_rdata"}, rdat, vecs[i].exp_data);
        chk({vecs[i].name, "_lat"},   64'(lat), 64'(RD_LAT));
      end
    end

    if_addr = 32'h8000_0014; #1 chk("fetch_upper", 64'(if_inst), 64'hCC223344);
    if_addr = 32'h8000_0010; #1 chk("fetch_lower", 64'(if_inst), 64'hBBBBBBBB);
    if_addr = 32'h7FFF_FFFC; #1 chk("fetch_below", 64'(if_inst), 64'h0);
    if_addr = 32'h8000_2010; #1 chk("fetch_alias", 64'(if_inst), 64'h0);
    step();

    // W leads AW by three edges
    bus.w_data = 64'h5555666677778888; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    chk("wfirst_w_ready",  64'(bus.w_ready),  64'h0);
    chk("wfirst_aw_ready", 64'(bus.aw_ready), 64'h1);
    step();
    step();
    chk("wfirst_no_b", 64'(bus.b_valid), 64'h0);
    bus.aw_addr = 32'h8000_0018; bus.aw_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0;
    chk("wfirst_b_valid", 64'(bus.b_valid), 64'h1);
    chk("wfirst_b_resp",  64'(bus.b_resp),  64'h0);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    chk("wfirst_aw_ready_back", 64'(bus.aw_ready), 64'h1);
    chk("wfirst_w_ready_back",  64'(bus.w_ready),  64'h1);
    model_write(32'h8000_0018, 64'h5555666677778888, 8'hFF);
    do_read(32'h8000_0018, rdat, resp, lat);
    chk("wfirst_rdata", rdat, exp_read(32'h8000_0018));

    // R held without r_ready
    bus.ar_addr = 32'h8000_0018; bus.ar_valid = 1'b1;
    step();
    bus.ar_valid = 1'b0;
    n = 0;
    while (!bus.r_valid && n < 20) begin step(); n++; end
    if (!bus.r_valid) timeout("hold_r");
    held = bus.r_data;
    for (int k = 0; k < 5; k++) begin
      chk("hold_r_valid",  64'(bus.r_valid),  64'h1);
      chk("hold_r_data",   bus.r_data,        64'h5555666677778888);
      chk("hold_ar_ready", 64'(bus.ar_ready), 64'h0);
      step();
    end
    chk("hold_r_data_stable", bus.r_data, held);
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    chk("hold_ar_ready_after", 64'(bus.ar_ready), 64'h1);
    chk("hold_r_valid_after",  64'(bus.r_valid),  64'h0);

    // Read sample and write commit on the same edge to the same word
    do_write(32'h8000_0020, 64'h0F0F0F0F0F0F0F0F, 8'hFF, resp);
    model_write(32'h8000_0020, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    bus.ar_addr = 32'h8000_0020; bus.ar_valid = 1'b1;
    bus.aw_addr = 32'h8000_0020; bus.aw_valid = 1'b1;
    bus.w_data  = 64'hF0F0F0F0F0F0F0F0; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    step();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("coll_b_valid", 64'(bus.b_valid), 64'h1);
    n = 0;
    while (!bus.r_valid && n < 20) begin step(); n++; end
    if (!bus.r_valid) timeout("coll_r");
    chk("coll_pre_write", bus.r_data, exp_read(32'h8000_0020));
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    step();
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    model_write(32'h8000_0020, 64'hF0F0F0F0F0F0F0F0, 8'hFF);
    do_read(32'h8000_0020, rdat, resp, lat);
    chk("coll_post_write", rdat, exp_read(32'h8000_0020));

    // Reset while a read waits and a W is captured without its AW
    bus.w_data  = 64'h0BADC0DE0BADC0DE; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    bus.ar_addr = 32'h8000_0018; bus.ar_valid = 1'b1;
    step();
    bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    chk("mid_pre_ar_ready", 64'(bus.ar_ready), 64'h0);
    chk("mid_pre_w_ready",  64'(bus.w_ready),  64'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ar_ready", 64'(bus.ar_ready), 64'h1);
    chk("mid_rst_w_ready",  64'(bus.w_ready),  64'h1);
    chk("mid_rst_r_valid",  64'(bus.r_valid),  64'h0);
    chk("mid_rst_r_data",   bus.r_data,        64'h0);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_stale_r", 64'(bus.r_valid), 64'h0);
    end
    bus.aw_addr = 32'h8000_0028; bus.aw_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0;
    step();
    step();
    chk("mid_w_lost", 64'(bus.b_valid), 64'h0);
    bus.w_data = 64'h7766554433221100; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    chk("mid_w_commit_b", 64'(bus.b_valid), 64'h1);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    model_write(32'h8000_0028, 64'h7766554433221100, 8'hFF);
    do_read(32'h8000_0028, rdat, resp, lat);
    chk("mid_new_data", rdat, exp_read(32'h8000_0028));
    do_read(32'h8000_0018, rdat, resp, lat);
    chk("mid_kept_data", rdat, exp_read(32'h8000_0018));

    // Random traffic over a 16-word window plus out-of-range addresses
    for (int w = 0; w < 16; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      do_write(BASE + 32'(w * 8), d, 8'hFF, resp);
      model_write(BASE + 32'(w * 8), d, 8'hFF);
    end
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      int          op;
      op = int'($urandom_range(0, 9));
      if (op == 4 || op == 9) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 32'(8 * $urandom_range(1, 1000));
        else                           a = BASE + 32'(SPAN) + 32'(8 * $urandom_range(0, 15));
      end else begin
        a = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
      end
      if (op <= 4) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        do_write(a, d, s, resp);
        chk("rand_bresp", 64'(resp), 64'(exp_resp(a)));
        model_write(a, d, s);
      end else begin
        do_read(a, rdat, resp, lat);
        chk("rand_rresp", 64'(resp), 64'(exp_resp(a)));
        chk("rand_rdata", rdat, exp_read(a));
        chk("rand_lat",   64'(lat), 64'(RD_LAT));
      end
      if ($urandom_range(0, 7) == 0) if_addr = BASE - 32'(4 * $urandom_range(1, 64));
      else                           if_addr = BASE + 32'(4 * $urandom_range(0, 31));
      #1 chk("rand_fetch", 64'(if_inst), 64'(exp_fetch(if_addr)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
